// File: rtl/slot_pkg.sv
// slot_pkg: shared entry-decoder types and constants
package slot_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO, HOLD} entry_state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: two BCD digits to 7-bit binary
module bcd_to_bin
  import slot_pkg::*;
(
  input  bcd_t       tens,
  input  bcd_t       ones,
  output logic [6:0] bin
);
  always_comb bin = ({3'd0, tens} << 3) + ({3'd0, tens} << 1) + {3'd0, ones};
endmodule

// File: rtl/bet_entry_decoder.sv
// bet_entry_decoder: keyed BCD entry to range-checked binary value on valid/ready
module bet_entry_decoder
  import slot_pkg::*;
#(
  parameter int OUT_W     = 4,
  parameter int MAX_VALUE = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       digit_in,
  input  logic             digit_strobe,
  input  logic             enter,
  input  logic             clear,
  input  logic             value_ready,
  output logic [OUT_W-1:0] value_out,
  output logic             value_valid,
  output logic             error,
  output logic [3:0]       echo_digits [1:0],
  output logic [1:0]       digit_count
);
  if (MAX_VALUE > 99 || MAX_VALUE > (1 << OUT_W) - 1) begin : g_bad_max
    $error("MAX_VALUE out of range");
  end
  entry_state_t     state_q, state_d;
  bcd_t             ones_q, ones_d, tens_q, tens_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             valid_q, valid_d, error_q, error_d;
  logic [6:0]       bin;
  logic             bad_digit;
  bcd_to_bin u_conv (.tens(tens_q), .ones(ones_q), .bin(bin));
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    error_d   = 1'b0;
    bad_digit = digit_in > BCD_MAX;
    if (clear || (state_q == HOLD && value_ready)) begin
      state_d = EMPTY;
      ones_d  = '0;
      tens_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == HOLD) begin
      state_d = HOLD;
    end else if (enter) begin
      if (state_q == EMPTY) begin
        error_d = 1'b1;
      end else if (32'(bin) > MAX_VALUE) begin
        error_d = 1'b1;
        state_d = EMPTY;
        ones_d  = '0;
        tens_d  = '0;
        cnt_d   = '0;
      end else begin
        value_d = OUT_W'(bin);
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end else if (digit_strobe) begin
      if (bad_digit || state_q == TWO) begin
        error_d = 1'b1;
      end else begin
        ones_d  = digit_in;
        tens_d  = state_q == ONE ? ones_q : '0;
        cnt_d   = state_q == ONE ? 2'd2 : 2'd1;
        state_d = state_q == ONE ? TWO : ONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      ones_q  <= '0;
      tens_q  <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end
  always_comb begin
    value_out      = value_q;
    value_valid    = valid_q;
    error          = error_q;
    echo_digits[0] = ones_q;
    echo_digits[1] = tens_q;
    digit_count    = cnt_q;
  end
endmodule

// File: doc/bet_entry_decoder.md
# bet_entry_decoder

Converts a player's keyed decimal entry, one BCD digit at a time, into a binary value for the slot-machine core. It performs the inverse of the display path, which splits a binary result into decimal digits. It sits between the keypad/button debouncer and the game controller. It echoes the digits being typed in the same two-digit format the display path consumes, then presents the checked binary value on a valid/ready handshake.

## Interface
- `OUT_W`, default 4: width of the binary result.
- `MAX_VALUE`, default 15: largest accepted value. It must be ≤ 99 and ≤ 2^OUT_W−1; elaboration fails otherwise.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `digit_in`  in  4: BCD digit, sampled only when `digit_strobe` is high.
- `digit_strobe`  in  1: one-cycle pulse, one digit keyed.
- `enter`  in  1: one-cycle pulse, commits the entry.
- `clear`  in  1: one-cycle pulse, discards the entry.
- `value_ready`  in  1: consumer accepts `value_out`.
- `value_out`  out  OUT_W: committed binary value.
- `value_valid`  out  1: `value_out` is held for the consumer.
- `error`  out  1: one-cycle pulse on a rejected event.
- `echo_digits`  out  4 × [1:0] unpacked: typed digits, index 0 = ones, index 1 = tens.
- `digit_count`  out  2: number of digits held, 0–2.

## Operation
- FSM states: `EMPTY`, `ONE`, `TWO`, `HOLD`.
- Per-cycle event priority is `clear` > `enter` > `digit_strobe`. Lower-priority events in the same cycle are dropped silently.
- `clear` in any state:
  - Go to `EMPTY`; digits zeroed; `value_valid` deasserted.
  - No `error`.
- `digit_strobe` with `digit_in` > 9, in `EMPTY`/`ONE`/`TWO`: `error` pulse; state and digits unchanged.
- `digit_strobe` in `EMPTY`: ones ← digit, tens ← 0; go to `ONE`.
- `digit_strobe` in `ONE`: tens ← ones, ones ← digit; go to `TWO`. A leading zero is legal.
- `digit_strobe` in `TWO`: `error` pulse; digits unchanged.
- `enter` in `EMPTY`: `error` pulse; stay in `EMPTY`.
- `enter` in `ONE`/`TWO`:
  - v = tens×10 + ones, computed at 7 bits.
  - If v > `MAX_VALUE`: `error` pulse, digits zeroed, go to `EMPTY`.
  - Otherwise: `value_out` ← v[OUT_W−1:0], `value_valid` ← 1, go to `HOLD`.
- `HOLD`:
  - `value_out` is stable and `value_valid` stays high until `value_ready` is sampled high. Then go to `EMPTY`, digits zeroed, `value_valid` ← 0.
  - `digit_strobe` and `enter` are ignored with no `error`.
- `echo_digits` and `digit_count` always reflect the registered digits. In `HOLD` they keep showing the committed entry.

## Timing
- All outputs are registered.
- Reset values: `value_out`=0, `value_valid`=0, `error`=0, `echo_digits`={0,0}, `digit_count`=0, state `EMPTY`.
- Reset mid-entry or in `HOLD` discards everything. `reset` overrides all inputs in the same cycle.
- `echo_digits`/`digit_count` update the cycle after the strobe.
- `value_valid` rises the cycle after `enter` is sampled.
- `error` is high for exactly the cycle after the offending event.
- Handshake: transfer occurs on the edge where `value_valid` and `value_ready` are both high. `value_valid` is low the following cycle.
- `value_ready` asserted while `value_valid` is low has no effect.
- A `digit_strobe` in the transfer cycle is ignored, because the state is still `HOLD`. The first accepted digit is one cycle later.
- Minimum entry-to-value latency is 2 cycles (strobe, then enter). Inputs are assumed synchronous and single-cycle pulses.

## Structure
- Shared package `slot_pkg` holds:
  - the state enum `entry_state_t`;
  - constant `BCD_MAX = 9`;
  - the digit type `bcd_t` (`logic [3:0]`).
- One combinational sub-module, `bcd_to_bin`: two BCD digits in, 7-bit binary out (tens×10 + ones). It is instantiated once; the range check lives in the parent.

## Test plan
- Reset, then strobe 1, strobe 2, enter; hold `value_ready` low 3 cycles, then high → `echo_digits`={2,1} (index 0 = 2, ones; index 1 = 1, tens), `value_out`=12, `value_valid` high 4 cycles and low the cycle after acceptance, `error` never high.
- Strobe 1, strobe 6, enter → one `error` pulse, `value_valid` stays 0, `digit_count`=0. Repeat with 0, 7 → `value_out`=7 (leading zero).
- Strobe 5, strobe 3, strobe 4 → `error` pulse on the third strobe, `echo_digits`={3,5} (index 0 = 3, ones; index 1 = 5, tens). Strobe with `digit_in`=11 → `error`, digits unchanged.
- `enter` from `EMPTY` → `error` pulse. `clear` and `enter` in the same cycle with 2 digits held → `EMPTY`, no `error`, no `value_valid`.
- In `HOLD` with `value_out`=9: strobe 4 and enter → ignored, no `error`. `clear` → `value_valid` drops next cycle.
- Assert `reset` in `TWO` and again in `HOLD` → all outputs zero next cycle. A subsequent strobe 8, enter, then `value_ready` high → `value_out`=8 (an enter pulse is required before `value_out` updates).
